// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 decryption core: forward key expansion to round key 10, then
// ten inverse rounds with an on-the-fly inverse key schedule, one round per clock.

module aes_gf_inv (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] r;
    // a^254 == a^-1 in GF(2^8); the ladder builds a^(2^k-1) up to a^127, then squares.
    always_comb begin
        r = a_i;
        for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), a_i);
        y_o = gmul(r, r);
    end
endmodule

module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);
    logic [7:0] inv;
    aes_gf_inv u_inv (.a_i(a_i), .y_o(inv));
    assign s_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_inv_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);
    logic [7:0] pre;
    assign pre = {a_i[6:0], a_i[7]} ^ {a_i[4:0], a_i[7:5]} ^ {a_i[1:0], a_i[7:2]} ^ 8'h05;
    aes_gf_inv u_inv (.a_i(pre), .y_o(s_o));
endmodule

module aes_inv_cipher (
    input  logic         AES_clk,
    input  logic         AES_rst_n,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid,
    output logic         AES_busy
);
    typedef enum logic [1:0] {IDLE, KEXP, ROUND} state_e;

    state_e       fsm_q;
    logic         en_q, valid_q, busy_q;
    logic [3:0]   rnd_q;
    logic [127:0] state_q, key_q, data_out_q;

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3], m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3], mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // One SubWord serves both schedules: forward uses w3, inverse uses w3^w2 (= previous w3).
    logic        kexp;
    logic [31:0] w0, w1, w2, w3, sw_in, sw_rot, sw_out, rc_w;
    logic [31:0] f0, f1, f2, f3;
    assign kexp   = (fsm_q == KEXP);
    assign {w0, w1, w2, w3} = key_q;
    assign sw_in  = kexp ? w3 : (w3 ^ w2);
    assign sw_rot = {sw_in[23:0], sw_in[31:24]};
    assign rc_w   = {rcon(kexp ? rnd_q : rnd_q + 4'd1), 24'h0};

    for (genvar b = 0; b < 4; b++) begin : g_ksb
        aes_sbox u_sb (.a_i(sw_rot[31-8*b -: 8]), .s_o(sw_out[31-8*b -: 8]));
    end

    logic [127:0] key_fwd_d, key_prev_d, isb, plain_d, imc_d;
    assign f0         = w0 ^ sw_out ^ rc_w;
    assign f1         = w1 ^ f0;
    assign f2         = w2 ^ f1;
    assign f3         = w3 ^ f2;
    assign key_fwd_d  = {f0, f1, f2, f3};
    assign key_prev_d = {w0 ^ sw_out ^ rc_w, w1 ^ w0, w2 ^ w1, w3 ^ w2};

    // InvShiftRows folded into the S-box wiring: out[r][c] = in[r][(c-r) mod 4].
    for (genvar i = 0; i < 16; i++) begin : g_isb
        localparam int SRC = 4 * (((i / 4) + 4 - (i % 4)) % 4) + (i % 4);
        aes_inv_sbox u_isb (.a_i(state_q[127-8*SRC -: 8]), .s_o(isb[127-8*i -: 8]));
    end

    assign plain_d = isb ^ key_prev_d;
    for (genvar c = 0; c < 4; c++) begin : g_imc
        assign imc_d[127-32*c -: 32] = inv_mix_col(plain_d[127-32*c -: 32]);
    end

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            fsm_q      <= IDLE;
            en_q       <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            rnd_q      <= '0;
            state_q    <= '0;
            key_q      <= '0;
            data_out_q <= '0;
        end else begin
            en_q    <= AES_en;
            valid_q <= 1'b0;
            case (fsm_q)
                IDLE: if (AES_en && !en_q) begin
                    state_q <= AES_data_in;
                    key_q   <= AES_key_in;
                    rnd_q   <= 4'd1;
                    busy_q  <= 1'b1;
                    fsm_q   <= KEXP;
                end
                KEXP: begin
                    key_q <= key_fwd_d;
                    if (rnd_q == 4'd10) begin
                        state_q <= state_q ^ key_fwd_d;
                        rnd_q   <= 4'd9;
                        fsm_q   <= ROUND;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                ROUND: if (rnd_q != 4'd0) begin
                    state_q <= imc_d;
                    key_q   <= key_prev_d;
                    rnd_q   <= rnd_q - 4'd1;
                end else begin
                    data_out_q <= plain_d;
                    valid_q    <= 1'b1;
                    busy_q     <= 1'b0;
                    fsm_q      <= IDLE;
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign AES_data_out       = data_out_q;
    assign AES_data_out_valid = valid_q;
    assign AES_busy           = busy_q;
endmodule

// File: tb/tb_aes_inv_cipher.sv
// Bench for aes_inv_cipher: known FIPS-197 vectors plus random blocks checked against
// a table-driven AES-128 encryption model (ciphertext from model, plaintext expected back).

module tb_aes_inv_cipher;
    logic         AES_clk, AES_rst_n, AES_en;
    logic [127:0] AES_data_in, AES_key_in, AES_data_out;
    logic         AES_data_out_valid, AES_busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] sb [256];

    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes_inv_cipher dut (
        .AES_clk(AES_clk), .AES_rst_n(AES_rst_n), .AES_en(AES_en),
        .AES_data_in(AES_data_in), .AES_key_in(AES_key_in),
        .AES_data_out(AES_data_out), .AES_data_out_valid(AES_data_out_valid),
        .AES_busy(AES_busy)
    );

    initial AES_clk = 1'b0;
    always #5 AES_clk = ~AES_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = xt(a);
        end
        return p;
    endfunction

    // S-box from its definition: brute-force multiplicative inverse, then affine map.
    task automatic build_sbox();
        logic [7:0] inv, c, s;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int b = 0; b < 8; b++)
                s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
            sb[x] = s;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [31:0]  tmp;
        logic [127:0] r;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int j = 0; j < 16; j++) s[j] = sb[s[j]];
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++) t[4*c+rw] = s[4*((c+rw)%4)+rw];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (rd < 10) begin
                    s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
                    s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int j = 0; j < 16; j++) s[j] ^= w[4*rd + j/4][31-8*(j%4) -: 8];
        end
        for (int j = 0; j < 16; j++) r[127-8*j -: 8] = s[j];
        return r;
    endfunction

    // Start one block and return its output and the edge count from capture to valid.
    task automatic run_block(input logic [127:0] ct, input logic [127:0] key,
                             output logic [127:0] out, output int lat);
        @(negedge AES_clk);
        AES_data_in = ct; AES_key_in = key; AES_en = 1'b1;
        @(posedge AES_clk);
        @(negedge AES_clk);
        AES_en = 1'b0;
        lat = 0;
        while (!AES_data_out_valid && lat < 40) begin
            @(negedge AES_clk);
            lat++;
        end
        out = AES_data_out;
    endtask

    task automatic test_reset();
        AES_rst_n = 1'b0; AES_en = 1'b0; AES_data_in = '0; AES_key_in = '0;
        repeat (3) @(negedge AES_clk);
        n_cmp++; if (AES_data_out !== 128'h0) begin n_err++; $display("FAIL reset_out: got %h want 0", AES_data_out); end
        n_cmp++; if (AES_data_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", AES_data_out_valid); end
        n_cmp++; if (AES_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", AES_busy); end
        AES_rst_n = 1'b1;
        repeat (2) @(negedge AES_clk);
        n_cmp++; if (AES_busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", AES_busy); end
    endtask

    task automatic test_fips_b();
        logic [127:0] out; int lat;
        run_block(B_CT, B_KEY, out, lat);
        n_cmp++; if (out !== B_PT) begin n_err++; $display("FAIL fips_b_out: got %h want %h", out, B_PT); end
        n_cmp++; if (lat !== 20) begin n_err++; $display("FAIL fips_b_latency: got %0d want 20", lat); end
        n_cmp++; if (AES_busy !== 1'b0) begin n_err++; $display("FAIL fips_b_busy_done: got %b want 0", AES_busy); end
        @(negedge AES_clk);
        n_cmp++; if (AES_data_out_valid !== 1'b0) begin n_err++; $display("FAIL fips_b_pulse_width: got %b want 0", AES_data_out_valid); end
        n_cmp++; if (AES_data_out !== B_PT) begin n_err++; $display("FAIL fips_b_hold: got %h want %h", AES_data_out, B_PT); end
    endtask

    task automatic test_c1_trace();
        @(negedge AES_clk);
        AES_data_in = C_CT; AES_key_in = C_KEY; AES_en = 1'b1;
        @(posedge AES_clk);
        @(negedge AES_clk);
        AES_en = 1'b0;
        n_cmp++; if (AES_busy !== 1'b1) begin n_err++; $display("FAIL c1_busy: got %b want 1", AES_busy); end
        repeat (10) @(negedge AES_clk);
        n_cmp++; if (dut.key_q !== C_RK10) begin n_err++; $display("FAIL c1_rk10: got %h want %h", dut.key_q, C_RK10); end
        repeat (9) @(negedge AES_clk);
        n_cmp++; if (AES_data_out_valid !== 1'b0) begin n_err++; $display("FAIL c1_early_valid: got %b want 0", AES_data_out_valid); end
        @(negedge AES_clk);
        n_cmp++; if (AES_data_out_valid !== 1'b1) begin n_err++; $display("FAIL c1_valid_e20: got %b want 1", AES_data_out_valid); end
        n_cmp++; if (AES_data_out !== C_PT) begin n_err++; $display("FAIL c1_out: got %h want %h", AES_data_out, C_PT); end
    endtask

    task automatic test_zero_hold();
        int pulses;
        pulses = 0;
        @(negedge AES_clk);
        AES_data_in = Z_CT; AES_key_in = '0; AES_en = 1'b1;
        @(posedge AES_clk);
        @(negedge AES_clk);
        for (int k = 1; k <= 51; k++) begin
            if (k == 5) begin
                AES_data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
                AES_key_in  = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            @(negedge AES_clk);
            if (AES_data_out_valid) pulses++;
        end
        AES_en = 1'b0;
        n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL held_en_pulses: got %0d want 1", pulses); end
        n_cmp++; if (AES_data_out !== 128'h0) begin n_err++; $display("FAIL zero_key_out: got %h want 0", AES_data_out); end
    endtask

    task automatic test_roundtrip();
        logic [127:0] key, pt, ct, out; int lat;
        key = 128'haa2bdb40bff6a5e8caa9ba3ebc1e2acc;
        pt  = 128'h000000f0000000000000000000000000;
        ct  = aes_enc(pt, key);
        run_block(ct, key, out, lat);
        n_cmp++; if (out !== pt) begin n_err++; $display("FAIL roundtrip_out: got %h want %h", out, pt); end
    endtask

    task automatic test_random();
        logic [127:0] key, pt, ct, out; int lat;
        for (int n = 0; n < 8; n++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            ct  = aes_enc(pt, key);
            run_block(ct, key, out, lat);
            n_cmp++; if (out !== pt) begin n_err++; $display("FAIL random_%0d_out: got %h want %h", n, out, pt); end
            n_cmp++; if (lat !== 20) begin n_err++; $display("FAIL random_%0d_latency: got %0d want 20", n, lat); end
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] out; int lat;
        @(negedge AES_clk);
        AES_data_in = C_CT; AES_key_in = C_KEY; AES_en = 1'b1;
        @(posedge AES_clk);
        @(negedge AES_clk);
        AES_en = 1'b0;
        repeat (11) @(negedge AES_clk);
        @(posedge AES_clk);
        #1 AES_rst_n = 1'b0;
        #1;
        n_cmp++; if (AES_data_out !== 128'h0) begin n_err++; $display("FAIL midreset_out: got %h want 0", AES_data_out); end
        n_cmp++; if (AES_busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b want 0", AES_busy); end
        n_cmp++; if (AES_data_out_valid !== 1'b0) begin n_err++; $display("FAIL midreset_valid: got %b want 0", AES_data_out_valid); end
        @(negedge AES_clk);
        AES_rst_n = 1'b1;
        run_block(C_CT, C_KEY, out, lat);
        n_cmp++; if (out !== C_PT) begin n_err++; $display("FAIL after_reset_out: got %h want %h", out, C_PT); end
        n_cmp++; if (lat !== 20) begin n_err++; $display("FAIL after_reset_latency: got %0d want 20", lat); end
    endtask

    task automatic test_back_to_back();
        int           pulses;
        int           at [2];
        logic [127:0] got [2];
        pulses = 0; at[0] = -1; at[1] = -1; got[0] = '0; got[1] = '0;
        @(negedge AES_clk);
        AES_data_in = B_CT; AES_key_in = B_KEY; AES_en = 1'b1;
        @(posedge AES_clk);
        @(negedge AES_clk);
        AES_en = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            if (k == 15) AES_en = 1'b1;
            if (k == 16) AES_en = 1'b0;
            if (k == 21) begin AES_en = 1'b1; AES_data_in = C_CT; AES_key_in = C_KEY; end
            if (k == 22) AES_en = 1'b0;
            @(negedge AES_clk);
            if (AES_data_out_valid) begin
                if (pulses < 2) begin at[pulses] = k; got[pulses] = AES_data_out; end
                pulses++;
            end
        end
        n_cmp++; if (pulses !== 2) begin n_err++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
        n_cmp++; if (at[0] !== 20) begin n_err++; $display("FAIL b2b_first_at: got %0d want 20", at[0]); end
        n_cmp++; if (got[0] !== B_PT) begin n_err++; $display("FAIL b2b_first_out: got %h want %h", got[0], B_PT); end
        n_cmp++; if (at[1] !== 41) begin n_err++; $display("FAIL b2b_second_at: got %0d want 41", at[1]); end
        n_cmp++; if (got[1] !== C_PT) begin n_err++; $display("FAIL b2b_second_out: got %h want %h", got[1], C_PT); end
    endtask

    initial begin
        AES_rst_n = 1'b0; AES_en = 1'b0; AES_data_in = '0; AES_key_in = '0;
        build_sbox();
        test_reset();
        test_fips_b();
        test_c1_trace();
        test_zero_hold();
        test_roundtrip();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/aes_inv_cipher.md
# aes_inv_cipher

Iterative AES-128 decryption core: the inverse of the AES_top encryption datapath, sharing its port naming and start/valid protocol. It accepts a 128-bit ciphertext and the 128-bit cipher key (the original key, not the last round key), derives round key 10 internally by forward expansion, then runs the ten inverse rounds with an on-the-fly inverse key schedule, one round per clock. It sits beside AES_top so round-trip encrypt→decrypt benches and side-channel VCD/SDF flows can exercise both directions.

## Interface
Parameters: none. AES-128 only; Nk=4 and Nr=10 are fixed.
- AES_clk  input  1  Single clock; all state updates on the rising edge.
- AES_rst_n  input  1  Asynchronous, active-low reset.
- AES_en  input  1  Start request; its rising edge, sampled while idle, starts one block.
- AES_data_in  input  128  Ciphertext; bit 127 is state byte 0 (FIPS-197 column-major order).
- AES_key_in  input  128  Cipher key, same byte order.
- AES_data_out  output  128  Recovered plaintext; holds its value until the next completion.
- AES_data_out_valid  output  1  One-cycle pulse marking a new AES_data_out.
- AES_busy  output  1  High from the capture edge until the completion edge.

## Operation
- Registers: en_d (last sample of AES_en), state_reg[127:0], key_reg[127:0], rnd[3:0], fsm[1:0], plus the outputs.
- Reset values: all registers 0. Outputs AES_data_out = 0, AES_data_out_valid = 0, AES_busy = 0. FSM = IDLE.
- FSM states and transitions:
  - IDLE: if AES_en && !en_d, then state_reg <= AES_data_in, key_reg <= AES_key_in, rnd <= 1, go to KEXP. Otherwise stay.
  - KEXP: key_reg <= fwd_expand(key_reg, rcon[rnd]) and rnd++.
    - On rnd=10 the expanded value is round key 10. On that edge also set state_reg <= AES_data_in_reg ^ rk10 (initial AddRoundKey), set rnd <= 9, and go to ROUND.
    - A separate data register holds the captured ciphertext during KEXP. state_reg may hold it instead.
  - ROUND: compute prev = inv_expand(key_reg, rcon[rnd+1]) combinationally. This is round key rnd.
    - t = InvSubBytes(InvShiftRows(state_reg)) ^ prev.
    - If rnd≠0: state_reg <= InvMixColumns(t), key_reg <= prev, rnd--.
    - If rnd=0: AES_data_out <= t, AES_data_out_valid <= 1, go to IDLE.
  - There is no separate DONE state.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36 (placed in byte 0 of the word).
- Inverse key step, with words w0..w3 of key_reg:
  - w3' = w3^w2, w2' = w2^w1, w1' = w1^w0.
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ rcon.
- InvMixColumns coefficients are {0e,0b,0d,09} over GF(2^8) with polynomial 0x11b, built from xtime chains. Multipliers are not used.
- S-box lookups (forward S-box for the key schedule, inverse S-box for the datapath) are separate combinational submodules: 4 forward and 16 inverse instances.
- Boundaries:
  - Inputs are ignored after the capture edge, so changing them mid-operation has no effect.
  - While busy, AES_en rising edges are ignored, and a held-high AES_en does not retrigger. en_d still tracks AES_en every cycle.
  - Reset asserted mid-operation clears everything immediately. The block returns to IDLE, AES_busy falls and AES_data_out goes to 0 asynchronously.
  - If AES_en rises on the completion edge, it is ignored (the FSM was in ROUND on that edge).

## Timing
- Edge E0 = first rising edge where AES_en=1 and en_d=0 in IDLE. AES_busy goes high after E0.
- E1..E10 are the KEXP edges. E10 loads the initial AddRoundKey.
- E11..E19 are inverse rounds 9..1. E20 is the final round.
- After E20: AES_data_out is valid, AES_data_out_valid=1 and AES_busy=0. Latency is 20 cycles from capture.
- AES_data_out_valid clears at E21.
- Back-to-back operation: AES_en low at E20 and high at E21 starts the next block at E21 (21-cycle period).

## Test plan
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, in 3925841d02dc09fbdc118597196a0b32 → out 3243f6a8885a308d313198a2e0370734, valid pulse exactly at E20 for 1 cycle.
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, in 69c4e0d86a7b0430d8cdb78070b4c55a → out 00112233445566778899aabbccddeeff. Also check that the key_reg trace after E10 equals round key 10, 13111d7fe3944a17f307a78b4d2b30c5.
- All-zero key, in 66e94bd4ef8a2c3b884cfa59ca342b2e → out 0. AES_en held high for 51 cycles → exactly one valid pulse. Changing AES_data_in at E5 → result unchanged.
- Round trip: feed AES_top's output for key aa2bdb40bff6a5e8caa9ba3ebc1e2acc, plaintext 000000f0…00 → out 000000f0000000000000000000000000.
- Pulse AES_rst_n low at E12 during C.1 → all outputs 0, busy 0. A fresh start afterwards yields the correct C.1 result at its own E20.
- Back-to-back B then C.1 vectors with AES_en toggled at E20/E21 → two correct valid pulses 21 cycles apart. A rise at E15 is ignored.
